// File: rtl/voice_pkg.sv
// Shared types and helpers for the voice scheduler slice.
package voice_pkg;

  localparam int NW_DEF = 7;
  localparam int VW_DEF = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // A note-on carrying velocity 0 is a note-off in MIDI running-status streams.
  function automatic logic note_on_eff(input logic on, input logic vel_nonzero);
    return on & vel_nonzero;
  endfunction

  // Width of a voice index; never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/voice_scheduler_if.sv
// Note-event handshake between the MIDI byte parser (master) and the scheduler (slave).
interface voice_scheduler_if #(
  parameter int NW = 7,
  parameter int VW = 7
);
  logic          ev_valid;
  logic          ev_ready;
  logic          ev_on;
  logic [NW-1:0] ev_note;
  logic [VW-1:0] ev_vel;

  modport master (output ev_valid, ev_on, ev_note, ev_vel, input ev_ready);
  modport slave  (input ev_valid, ev_on, ev_note, ev_vel, output ev_ready);
endinterface

// File: rtl/voice_age_tracker.sv
// Age ranks for the voice bank: rank 0 is the newest voice, rank VOICES-1 the oldest.
// The rank array is a permutation of 0..VOICES-1 at all times.
module voice_age_tracker
  import voice_pkg::*;
#(
  parameter int VOICES = 4,
  localparam int IW = idx_width(VOICES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic          touch_en,
  input  logic [IW-1:0] touch_idx,
  output logic [IW-1:0] oldest_idx
);

  logic [IW-1:0] r_rank [VOICES];

  // Touching a voice makes it newest; everything younger than it ages by one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < VOICES; i++) r_rank[i] <= IW'(i);
    end else if (ce && touch_en) begin
      for (int i = 0; i < VOICES; i++) begin
        if (IW'(i) == touch_idx)
          r_rank[i] <= '0;
        else if (r_rank[i] < r_rank[touch_idx])
          r_rank[i] <= r_rank[i] + 1'b1;
      end
    end
  end

  // Locate the voice holding the oldest rank.
  always_comb begin
    oldest_idx = '0;
    for (int i = 0; i < VOICES; i++) begin
      if (r_rank[i] == IW'(VOICES - 1)) oldest_idx = IW'(i);
    end
  end

endmodule

// File: rtl/voice_scheduler.sv
// Voice scheduler: assigns MIDI note events to a bank of synth voices.
// Each accepted event scans the voice table one entry per ce cycle, then commits.
// Optional macro VOICE_STEAL_EN: when defined, a note-on with no match and no free
// voice steals the oldest voice; otherwise it is dropped and ev_drop pulses.
module voice_scheduler
  import voice_pkg::*;
#(
  parameter int VOICES = 4,
  parameter int NW     = NW_DEF,
  parameter int VW     = VW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 all_off,
  voice_scheduler_if.slave     ev,
  output logic [VOICES*NW-1:0] voice_note,
  output logic [VOICES*VW-1:0] voice_vel,
  output logic [VOICES-1:0]    voice_gate,
  output logic [VOICES-1:0]    voice_trig,
  output logic                 ev_drop
);

  localparam int IW = idx_width(VOICES);

  state_t            r_state;
  logic [IW-1:0]     r_idx;
  logic              r_ev_on;
  logic [NW-1:0]     r_ev_note;
  logic [VW-1:0]     r_ev_vel;
  logic              r_match_vld;
  logic [IW-1:0]     r_match_idx;
  logic              r_free_vld;
  logic [IW-1:0]     r_free_idx;
  logic [NW-1:0]     r_note_a [VOICES];
  logic [VW-1:0]     r_vel_a  [VOICES];
  logic [VOICES-1:0] r_gate;
  logic [VOICES-1:0] r_trig;
`ifndef VOICE_STEAL_EN
  logic              r_drop;
`endif

  logic              w_tgt_vld;
  logic [IW-1:0]     w_tgt_idx;
  logic [IW-1:0]     w_oldest_idx;
  logic              w_touch;
  logic              w_last;

  assign ev.ev_ready = (r_state == IDLE) && !all_off;
  assign w_last      = (r_idx == IW'(VOICES - 1));

  // Commit target: retrigger beats a free voice, a free voice beats the oldest.
  // Without stealing, an all-busy table leaves w_tgt_vld low and nothing is written.
  always_comb begin
    w_tgt_vld = 1'b1;
    w_tgt_idx = r_free_idx;
    if (r_match_vld) begin
      w_tgt_idx = r_match_idx;
    end else if (!r_free_vld) begin
      w_tgt_idx = w_oldest_idx;
`ifndef VOICE_STEAL_EN
      w_tgt_vld = 1'b0;
`endif
    end
  end

  assign w_touch = ce && !all_off && (r_state == COMMIT) && r_ev_on && w_tgt_vld;

  voice_age_tracker #(.VOICES(VOICES)) u_age (
    .clk        (clk),
    .rst_n      (rst_n),
    .ce         (ce),
    .touch_en   (w_touch),
    .touch_idx  (w_tgt_idx),
    .oldest_idx (w_oldest_idx)
  );

  // Event FSM and voice table; pulses clear every clk so they stay one clk wide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_ev_on     <= 1'b0;
      r_ev_note   <= '0;
      r_ev_vel    <= '0;
      r_match_vld <= 1'b0;
      r_match_idx <= '0;
      r_free_vld  <= 1'b0;
      r_free_idx  <= '0;
      r_gate      <= '0;
      r_trig      <= '0;
      for (int i = 0; i < VOICES; i++) begin
        r_note_a[i] <= '0;
        r_vel_a[i]  <= '0;
      end
`ifndef VOICE_STEAL_EN
      r_drop      <= 1'b0;
`endif
    end else begin
      r_trig <= '0;
`ifndef VOICE_STEAL_EN
      r_drop <= 1'b0;
`endif
      if (ce) begin
        if (all_off) begin
          r_gate  <= '0;
          for (int i = 0; i < VOICES; i++) r_vel_a[i] <= '0;
          r_state <= IDLE;
        end else begin
          case (r_state)
            IDLE: begin
              if (ev.ev_valid) begin
                r_ev_on     <= note_on_eff(ev.ev_on, |ev.ev_vel);
                r_ev_note   <= ev.ev_note;
                r_ev_vel    <= ev.ev_vel;
                r_idx       <= '0;
                r_match_vld <= 1'b0;
                r_free_vld  <= 1'b0;
                r_state     <= SCAN;
              end
            end
            SCAN: begin
              if (!r_match_vld && r_gate[r_idx] && (r_note_a[r_idx] == r_ev_note)) begin
                r_match_vld <= 1'b1;
                r_match_idx <= r_idx;
              end
              if (!r_free_vld && !r_gate[r_idx]) begin
                r_free_vld <= 1'b1;
                r_free_idx <= r_idx;
              end
              if (w_last) r_state <= COMMIT;
              else        r_idx   <= r_idx + 1'b1;
            end
            COMMIT: begin
              if (r_ev_on) begin
                if (w_tgt_vld) begin
                  r_note_a[w_tgt_idx] <= r_ev_note;
                  r_vel_a[w_tgt_idx]  <= r_ev_vel;
                  r_gate[w_tgt_idx]   <= 1'b1;
                  r_trig[w_tgt_idx]   <= 1'b1;
                end else begin
`ifndef VOICE_STEAL_EN
                  r_drop <= 1'b1;
`endif
                end
              end else if (r_match_vld) begin
                r_gate[r_match_idx]  <= 1'b0;
                r_vel_a[r_match_idx] <= '0;
              end
              r_state <= IDLE;
            end
            default: r_state <= IDLE;
          endcase
        end
      end
    end
  end

  for (genvar g = 0; g < VOICES; g++) begin : g_out
    assign voice_note[g*NW +: NW] = r_note_a[g];
    assign voice_vel[g*VW +: VW]  = r_vel_a[g];
  end

  assign voice_gate = r_gate;
  assign voice_trig = r_trig;
`ifdef VOICE_STEAL_EN
  assign ev_drop = 1'b0;
`else
  assign ev_drop = r_drop;
`endif

endmodule
